// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 funct3 encodings, the
// controller state type, and the pure helper functions used by lsu_align to
// classify, mask and extend memory accesses.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  // Stores only have the signed-size encodings; loads also allow BU/HU.
  function automatic logic op_illegal(input logic wen, input logic [2:0] f3);
    logic bad;
    case (f3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = wen;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic op_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3)
      F3_H, F3_HU: bad = off[0];
      F3_W:        bad = (off != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] byte_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    case (f3)
      F3_B:    m = 4'b0001 << off;
      F3_H:    m = 4'b0011 << off;
      F3_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] word,
                                              input logic [1:0] off);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {off, 3'b000};
    case (f3)
      F3_B:    r = {{24{sh[7]}}, sh[7:0]};
      F3_H:    r = {{16{sh[15]}}, sh[15:0]};
      F3_W:    r = word;
      F3_BU:   r = {24'h0, sh[7:0]};
      F3_HU:   r = {16'h0, sh[15:0]};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational alignment datapath for the load/store unit.
// Ports:
//   wen, funct3, off   - access direction, size encoding and byte offset addr[1:0]
//   wdata              - LSB-justified store data
//   rdata              - full aligned word returned by memory
//   wmask              - byte-lane write mask (0 for loads)
//   wdata_sh           - store data shifted into its byte lanes
//   rdata_ext          - load data extracted and sign/zero extended
//   err                - illegal funct3 for the direction, or misaligned
module lsu_align
  import lsu_pkg::*;
(
  input  logic        wen,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        err
);

  assign err       = op_illegal(wen, funct3) | op_misaligned(funct3, off);
  assign wmask     = wen ? byte_mask(funct3, off) : 4'b0000;
  assign wdata_sh  = wdata << {off, 3'b000};
  assign rdata_ext = load_extend(funct3, rdata, off);

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between EXU and the ram_dpi port. Single outstanding
// request: accept in IDLE, hold mem_valid for MEM_LATENCY cycles in ACCESS,
// then present the response in RESP until WBU takes it.
// Handshakes: a transfer happens on a posedge where valid and ready are both 1.
//   req: req_ready is 1 only in IDLE; req_* are sampled only on that edge.
//   rsp: rsp_valid/rsp_rdata/rsp_err stay constant until rsp_ready is seen.
// Ports:
//   clock, reset       - clock, synchronous active-high reset
//   req_*              - request from EXU (valid/ready, wen, funct3, addr, wdata)
//   rsp_*              - response to WBU (valid/ready, rdata, err)
//   mem_*              - ram_dpi access (valid, raddr, wen, waddr, wdata, wmask, rdata)
//   dbg_state          - current controller state (lsu_state_e encoding)
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int XLEN        = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            mem_valid,
  output logic [XLEN-1:0] mem_raddr,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_waddr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wmask,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [1:0]      dbg_state
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  lsu_state_e state;
  logic [CW-1:0] cnt;
  logic          lat_wen;
  logic [2:0]    lat_f3;
  logic [1:0]    lat_off;

  // The align block sees the live request while IDLE (for mask/shift/error)
  // and the latched request afterwards (for load extraction).
  logic        a_wen;
  logic [2:0]  a_f3;
  logic [1:0]  a_off;
  logic [3:0]  a_wmask;
  logic [31:0] a_wdata_sh;
  logic [31:0] a_rdata_ext;
  logic        a_err;

  assign a_wen = (state == ST_IDLE) ? req_wen        : lat_wen;
  assign a_f3  = (state == ST_IDLE) ? req_funct3     : lat_f3;
  assign a_off = (state == ST_IDLE) ? req_addr[1:0]  : lat_off;

  lsu_align u_align (
    .wen       (a_wen),
    .funct3    (a_f3),
    .off       (a_off),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .wmask     (a_wmask),
    .wdata_sh  (a_wdata_sh),
    .rdata_ext (a_rdata_ext),
    .err       (a_err)
  );

  assign dbg_state = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lat_wen   <= 1'b0;
      lat_f3    <= 3'b000;
      lat_off   <= 2'b00;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_valid <= 1'b0;
      mem_raddr <= '0;
      mem_wen   <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      mem_wmask <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_wen   <= req_wen;
            lat_f3    <= req_funct3;
            lat_off   <= req_addr[1:0];
            req_ready <= 1'b0;
            if (a_err) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state     <= ST_ACCESS;
              cnt       <= CW'(MEM_LATENCY - 1);
              mem_valid <= 1'b1;
              mem_raddr <= {req_addr[XLEN-1:2], 2'b00};
              mem_waddr <= {req_addr[XLEN-1:2], 2'b00};
              mem_wen   <= req_wen;
              mem_wdata <= req_wen ? a_wdata_sh : '0;
              mem_wmask <= {4'b0000, a_wmask};
            end
          end
        end
        ST_ACCESS: begin
          // Write strobe lasts one cycle so the DPI side sees a single write.
          mem_wen <= 1'b0;
          if (cnt == '0) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= lat_wen ? '0 : a_rdata_ext;
            mem_valid <= 1'b0;
            mem_raddr <= '0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            mem_wmask <= 8'h00;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with MEM_LATENCY=3.
module tb_lsu_mem_ctrl;

  localparam int ML = 3;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_valid;
  logic [31:0] mem_raddr;
  logic        mem_wen;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int mv_cnt = 0;
  logic [31:0] exp_q[$];

  lsu_mem_ctrl #(.MEM_LATENCY(ML), .XLEN(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_valid  (mem_valid),
    .mem_raddr  (mem_raddr),
    .mem_wen    (mem_wen),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_rdata  (mem_rdata),
    .dbg_state  (dbg_state)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // memory activity monitor, counted on the edges the DUT presents them
  always @(posedge clock) begin
    if (mem_valid) mv_cnt++;
    if (mem_valid && mem_wen) wr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    check("idle_after_ack", {30'd0, dbg_state}, 32'd0);
    check("ready_after_ack", {31'd0, req_ready}, 32'd1);
  endtask

  // driver: one full transaction with hand-computed expectations
  task automatic run_op(input string tag, input logic wen, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] word, input logic [31:0] exp_rd,
                        input logic exp_err, input logic [7:0] exp_wmask,
                        input logic [31:0] exp_wdata);
    int wr0, mv0, cyc;
    logic [31:0] e;
    exp_q.push_back(exp_rd);
    @(negedge clock);
    req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    mem_rdata = word;
    wr0 = wr_cnt; mv0 = mv_cnt;
    @(negedge clock);
    req_valid = 1'b0;
    if (!exp_err) begin
      check({tag, "_mvalid"}, {31'd0, mem_valid}, 32'd1);
      check({tag, "_mwen"}, {31'd0, mem_wen}, {31'd0, wen});
      check({tag, "_raddr"}, mem_raddr, {addr[31:2], 2'b00});
      if (wen) begin
        check({tag, "_waddr"}, mem_waddr, {addr[31:2], 2'b00});
        check({tag, "_wmask"}, {24'd0, mem_wmask}, {24'd0, exp_wmask});
        check({tag, "_wdata"}, mem_wdata, exp_wdata);
      end
    end
    wait_rsp(cyc);
    e = exp_q.pop_front();
    check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    check({tag, "_rdata"}, rsp_rdata, e);
    check({tag, "_nwrites"}, wr_cnt - wr0, (wen && !exp_err) ? 32'd1 : 32'd0);
    check({tag, "_nvalid"}, mv_cnt - mv0, exp_err ? 32'd0 : ML);
    ack_rsp();
  endtask

  initial begin
    int cyc;
    int wr0;
    reset = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clock);
    check("rst_mvalid", {31'd0, mem_valid}, 32'd0);
    check("rst_rvalid", {31'd0, rsp_valid}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("rst_ready", {31'd0, req_ready}, 32'd1);

    // stores
    run_op("sw", 1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0, 8'h0F, 32'hDEAD_BEEF);
    run_op("sb", 1'b1, 3'b000, 32'h8000_0003, 32'h0000_00AB, 32'h0, 32'h0, 1'b0, 8'h08, 32'hAB00_0000);
    run_op("sh", 1'b1, 3'b001, 32'h8000_0006, 32'h0000_1234, 32'h0, 32'h0, 1'b0, 8'h0C, 32'h1234_0000);
    // loads from 0x80FF_7F01
    run_op("lb3",  1'b0, 3'b000, 32'h8000_0013, 32'h0, 32'h80FF_7F01, 32'hFFFF_FF80, 1'b0, 8'h00, 32'h0);
    run_op("lbu3", 1'b0, 3'b100, 32'h8000_0013, 32'h0, 32'h80FF_7F01, 32'h0000_0080, 1'b0, 8'h00, 32'h0);
    run_op("lb1",  1'b0, 3'b000, 32'h8000_0011, 32'h0, 32'h80FF_7F01, 32'h0000_007F, 1'b0, 8'h00, 32'h0);
    run_op("lh2",  1'b0, 3'b001, 32'h8000_0012, 32'h0, 32'h80FF_7F01, 32'hFFFF_80FF, 1'b0, 8'h00, 32'h0);
    run_op("lhu0", 1'b0, 3'b101, 32'h8000_0010, 32'h0, 32'h80FF_7F01, 32'h0000_7F01, 1'b0, 8'h00, 32'h0);
    run_op("lhu2", 1'b0, 3'b101, 32'h8000_0012, 32'h0, 32'h80FF_7F01, 32'h0000_80FF, 1'b0, 8'h00, 32'h0);
    run_op("lw0",  1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'h80FF_7F01, 32'h80FF_7F01, 1'b0, 8'h00, 32'h0);
    // rejected requests
    run_op("lw_mis", 1'b0, 3'b010, 32'h8000_0002, 32'h0, 32'h1111_1111, 32'h0, 1'b1, 8'h00, 32'h0);
    run_op("sh_mis", 1'b1, 3'b001, 32'h8000_0001, 32'h55, 32'h0, 32'h0, 1'b1, 8'h00, 32'h0);
    run_op("ld_011", 1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'h2222_2222, 32'h0, 1'b1, 8'h00, 32'h0);
    run_op("st_100", 1'b1, 3'b100, 32'h8000_0000, 32'h77, 32'h0, 32'h0, 1'b1, 8'h00, 32'h0);

    // latency and back-pressure
    @(negedge clock);
    req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8000_0010;
    mem_rdata = 32'h1357_2468;
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      @(negedge clock);
      req_valid = 1'b0;
      cyc++;
    end
    check("lat_cycles", cyc, 32'd4);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_rdata", rsp_rdata, 32'h1357_2468);
      check("stall_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clock);
    end
    // new request presented together with the ack must wait a cycle
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'b000; req_addr = 32'h8000_0021;
    req_wdata = 32'h0000_005A;
    @(negedge clock);
    rsp_ready = 1'b0;
    check("ack_state", {30'd0, dbg_state}, 32'd0);
    check("ack_ready", {31'd0, req_ready}, 32'd1);
    check("ack_mvalid", {31'd0, mem_valid}, 32'd0);
    check("ack_rvalid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clock);
    req_valid = 1'b0;
    check("b2b_mvalid", {31'd0, mem_valid}, 32'd1);
    check("b2b_mwen", {31'd0, mem_wen}, 32'd1);
    check("b2b_wmask", {24'd0, mem_wmask}, 32'h0000_0002);
    check("b2b_wdata", mem_wdata, 32'h0000_5A00);
    check("b2b_waddr", mem_waddr, 32'h8000_0020);
    @(negedge clock);
    check("b2b_wen_once", {31'd0, mem_wen}, 32'd0);
    wait_rsp(cyc);
    check("b2b_rdata", rsp_rdata, 32'h0);
    ack_rsp();

    // reset during ACCESS cycle 2 of a store
    @(negedge clock);
    wr0 = wr_cnt;
    req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'b010; req_addr = 32'h8000_0040;
    req_wdata = 32'hCAFE_F00D;
    @(negedge clock);
    req_valid = 1'b0;
    check("abort_acc1", {30'd0, dbg_state}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_state", {30'd0, dbg_state}, 32'd0);
    check("abort_mvalid", {31'd0, mem_valid}, 32'd0);
    check("abort_mwen", {31'd0, mem_wen}, 32'd0);
    check("abort_waddr", mem_waddr, 32'h0);
    check("abort_wmask", {24'd0, mem_wmask}, 32'h0);
    check("abort_rvalid", {31'd0, rsp_valid}, 32'd0);
    check("abort_writes", wr_cnt - wr0, 32'd1);
    reset = 1'b0;
    @(negedge clock);
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge clock);
    check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
